// File: rtl/lm_sm_pkg.sv
// -----------------------------------------------------------------------------
// lm_sm_pkg
// Shared definitions for the LM/SM micro-op sequencer:
//   OP_LM / OP_SM   - opcodes (in_ir[15:12]) of load-multiple / store-multiple
//   NOP_IR_DEFAULT  - instruction word emitted for bubbles and flushes
//   state_t         - sequencer FSM state encoding (IDLE, SEQ)
//   is_multiple()   - true when an opcode is LM or SM
// -----------------------------------------------------------------------------
package lm_sm_pkg;

   localparam logic [3:0]  OP_LM          = 4'b0110;
   localparam logic [3:0]  OP_SM          = 4'b0111;
   localparam logic [15:0] NOP_IR_DEFAULT = 16'hF000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEQ  = 1'b1
   } state_t;

   function automatic logic is_multiple(input logic [3:0] op);
      return (op == OP_LM) || (op == OP_SM);
   endfunction

endpackage

// File: rtl/lm_sm_sequencer_prio_enc8.sv
// -----------------------------------------------------------------------------
// prio_enc8
// 8-bit lowest-set-bit priority encoder.
// Ports:
//   list_i [7:0] - register list
//   idx_o  [2:0] - index of the lowest set bit (0 when list_i is zero)
//   zero_o       - list_i has no bits set
// -----------------------------------------------------------------------------
module prio_enc8 (
   input  logic [7:0] list_i,
   output logic [2:0] idx_o,
   output logic       zero_o
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx_o = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (list_i[i]) idx_o = 3'(i);
      end
   end

   assign zero_o = (list_i == 8'h00);

endmodule

// File: rtl/lm_sm_sequencer.sv
// -----------------------------------------------------------------------------
// lm_sm_sequencer
// Splits LM/SM (load/store multiple) instructions into one micro-op per set
// bit of the register list, lowest index first; other instructions pass
// through with one cycle of latency.
//
// Ports:
//   clk, reset       - clock; asynchronous active-high reset
//   in_ir[15:0]      - upstream instruction (opcode [15:12], Ra [11:9], list [7:0])
//   in_valid         - in_ir holds a real instruction
//   stall_in         - downstream cannot take a micro-op; everything holds
//   flush            - squash: back to IDLE, emit NOP bubble (beats stall_in)
//   in_ready         - combinational; in_ir is consumed at this clock edge
//   out_ir[15:0]     - registered instruction word for the RR/EX register
//   out_valid        - out_ir is a real micro-op
//   reg_addr[2:0]    - register loaded/stored by this micro-op
//   first_multiple   - first micro-op of an LM/SM (EX uses Ra as base)
//   last_multiple    - final micro-op of an LM/SM
//   mem_en           - micro-op performs a memory access
//   state_dbg        - current FSM state, for observation only
//
// Handshake: an instruction is consumed on a rising edge where in_ready=1
// (no stall, IDLE); in_valid qualifies whether it is real. While an LM/SM is
// being expanded in_ready stays low and in_ir is ignored.
//
// Configuration macro LMSM_SKIP_EMPTY_EN: when defined, an LM/SM with an
// empty register list produces a NOP bubble; otherwise it produces a single
// non-memory micro-op flagged both first and last.
// -----------------------------------------------------------------------------
module lm_sm_sequencer
   import lm_sm_pkg::*;
#(
   parameter logic [15:0] NOP_IR = NOP_IR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in_ir,
   input  logic        in_valid,
   input  logic        stall_in,
   input  logic        flush,
   output logic        in_ready,
   output logic [15:0] out_ir,
   output logic        out_valid,
   output logic [2:0]  reg_addr,
   output logic        first_multiple,
   output logic        last_multiple,
   output logic        mem_en,
   output state_t      state_dbg
);

   state_t      state_q;
   logic [7:0]  rem_q;
   logic [15:0] out_ir_q;
   logic        out_valid_q;
   logic [2:0]  reg_addr_q;
   logic        first_q;
   logic        last_q;
   logic        mem_en_q;

   logic [7:0]  sel_list;
   logic [2:0]  enc_idx;
   logic        enc_zero;
   logic [7:0]  list_left;
   logic        is_mult;

   // One encoder serves both the fresh list (IDLE) and the remainder (SEQ).
   assign sel_list  = (state_q == ST_SEQ) ? rem_q : in_ir[7:0];
   assign list_left = sel_list & ~(8'h01 << enc_idx);
   assign is_mult   = is_multiple(in_ir[15:12]);

   prio_enc8 u_enc (
      .list_i (sel_list),
      .idx_o  (enc_idx),
      .zero_o (enc_zero)
   );

   assign in_ready = ~stall_in & (state_q == ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rem_q       <= 8'h00;
         out_ir_q    <= NOP_IR;
         out_valid_q <= 1'b0;
         reg_addr_q  <= 3'd0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         mem_en_q    <= 1'b0;
      end else if (flush) begin
         state_q     <= ST_IDLE;
         rem_q       <= 8'h00;
         out_ir_q    <= NOP_IR;
         out_valid_q <= 1'b0;
         reg_addr_q  <= 3'd0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         mem_en_q    <= 1'b0;
      end else if (!stall_in) begin
         if (state_q == ST_SEQ) begin
            // out_ir_q keeps the LM/SM word for every micro-op of the sequence.
            out_valid_q <= 1'b1;
            reg_addr_q  <= enc_idx;
            first_q     <= 1'b0;
            mem_en_q    <= 1'b1;
            rem_q       <= list_left;
            last_q      <= (list_left == 8'h00);
            if (list_left == 8'h00) state_q <= ST_IDLE;
         end else if (!in_valid) begin
            out_ir_q    <= NOP_IR;
            out_valid_q <= 1'b0;
            reg_addr_q  <= 3'd0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            mem_en_q    <= 1'b0;
         end else if (!is_mult) begin
            out_ir_q    <= in_ir;
            out_valid_q <= 1'b1;
            reg_addr_q  <= 3'd0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            mem_en_q    <= 1'b0;
         end else if (enc_zero) begin
`ifdef LMSM_SKIP_EMPTY_EN
            out_ir_q    <= NOP_IR;
            out_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
`else
            out_ir_q    <= in_ir;
            out_valid_q <= 1'b1;
            first_q     <= 1'b1;
            last_q      <= 1'b1;
`endif
            reg_addr_q  <= 3'd0;
            mem_en_q    <= 1'b0;
         end else begin
            out_ir_q    <= in_ir;
            out_valid_q <= 1'b1;
            reg_addr_q  <= enc_idx;
            first_q     <= 1'b1;
            mem_en_q    <= 1'b1;
            rem_q       <= list_left;
            last_q      <= (list_left == 8'h00);
            state_q     <= (list_left == 8'h00) ? ST_IDLE : ST_SEQ;
         end
      end
   end

   assign out_ir         = out_ir_q;
   assign out_valid      = out_valid_q;
   assign reg_addr       = reg_addr_q;
   assign first_multiple = first_q;
   assign last_multiple  = last_q;
   assign mem_en         = mem_en_q;
   assign state_dbg      = state_q;

endmodule
